// File: rtl/tradeoff_pkg.sv
// Shared types and default sizing for the Tradeoff_8bits W sequencer.
package tradeoff_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      RESULT = 2'd3
   } state_t;

   localparam int unsigned W_BITS_DEF   = 20;
   localparam int unsigned N_BITS_DEF   = 9;
   localparam int unsigned TO_BITS_DEF  = 10;
   localparam int unsigned TIMEOUT_DEF  = 1000;
   localparam int unsigned EXP_N_DEF    = 255;
   localparam int unsigned CNT_BITS_DEF = 16;

endpackage

// File: rtl/tradeoff_w_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   // Count up on inc, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (inc && (q != {WIDTH{1'b1}})) begin
         q <= q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/tradeoff_w_sequencer.sv
// Feeds W operands to the search core one at a time, waits for found or a
// watchdog expiry, and hands {W, N, pass, timeout} downstream with counters.
module tradeoff_w_sequencer
   import tradeoff_pkg::*;
#(
   parameter int unsigned W_BITS   = W_BITS_DEF,
   parameter int unsigned N_BITS   = N_BITS_DEF,
   parameter int unsigned TO_BITS  = TO_BITS_DEF,
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
   parameter int unsigned EXP_N    = EXP_N_DEF,
   parameter int unsigned CNT_BITS = CNT_BITS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W_BITS-1:0]   in_w,
   output logic [W_BITS-1:0]   core_w,
   output logic                core_start,
   input  logic                core_found,
   input  logic [N_BITS-1:0]   core_n,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [W_BITS-1:0]   res_w,
   output logic [N_BITS-1:0]   res_n,
   output logic                res_pass,
   output logic                res_timeout,
   output logic                busy,
   output logic [CNT_BITS-1:0] total_cnt,
   output logic [CNT_BITS-1:0] err_cnt
);

   localparam logic [TO_BITS-1:0] WD_LAST = TO_BITS'(TIMEOUT - 1);
   localparam logic [N_BITS-1:0]  N_GOOD  = N_BITS'(EXP_N);

   state_t             state;
   state_t             state_nxt;
   logic [TO_BITS-1:0] wd;
   logic               in_ready_nxt;
   logic               core_start_nxt;
   logic               res_valid_nxt;
   logic               busy_nxt;
   logic               res_done_c;
   logic               err_inc_c;

   assign res_done_c = res_valid && res_ready;
   assign err_inc_c  = res_done_c && !res_pass;

   // Next state plus the next value of every state-derived output.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid) state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT:    if (core_found || (wd == WD_LAST)) state_nxt = RESULT;
         RESULT:  if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      in_ready_nxt   = (state_nxt == IDLE);
      core_start_nxt = (state_nxt == START);
      res_valid_nxt  = (state_nxt == RESULT);
      busy_nxt       = (state_nxt != IDLE);
   end

   // State register with registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         core_start <= 1'b0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         in_ready   <= in_ready_nxt;
         core_start <= core_start_nxt;
         res_valid  <= res_valid_nxt;
         busy       <= busy_nxt;
      end
   end

   // Operand latch, watchdog and result capture; found beats watchdog expiry.
   always_ff @(posedge clk) begin
      if (rst) begin
         core_w      <= '0;
         res_w       <= '0;
         res_n       <= '0;
         res_pass    <= 1'b0;
         res_timeout <= 1'b0;
         wd          <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  core_w <= in_w;
                  res_w  <= in_w;
               end
            end
            START: wd <= '0;
            WAIT: begin
               wd <= wd + TO_BITS'(1);
               if (core_found) begin
                  res_n       <= core_n;
                  res_timeout <= 1'b0;
                  res_pass    <= (core_n == N_GOOD);
               end else if (wd == WD_LAST) begin
                  res_n       <= '0;
                  res_timeout <= 1'b1;
                  res_pass    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_BITS)) u_total_cnt (
      .clk (clk),
      .rst (rst),
      .inc (res_done_c),
      .q   (total_cnt)
   );

   sat_counter #(.WIDTH(CNT_BITS)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (err_inc_c),
      .q   (err_cnt)
   );

endmodule

// File: tb/tb_tradeoff_w_sequencer.sv
// Bench for tradeoff_w_sequencer: a behavioural search-core responder plus a
// transaction-level model of latency, result fields and saturating counters.
module tb_tradeoff_w_sequencer;

   localparam int W_BITS   = 20;
   localparam int N_BITS   = 9;
   localparam int TO_BITS  = 6;
   localparam int TIMEOUT  = 40;
   localparam int EXP_N    = 255;
   localparam int CNT_BITS = 4;
   localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [W_BITS-1:0]   in_w = '0;
   logic [W_BITS-1:0]   core_w;
   logic                core_start;
   logic                core_found = 1'b0;
   logic [N_BITS-1:0]   core_n = '0;
   logic                res_valid;
   logic                res_ready = 1'b0;
   logic [W_BITS-1:0]   res_w;
   logic [N_BITS-1:0]   res_n;
   logic                res_pass;
   logic                res_timeout;
   logic                busy;
   logic [CNT_BITS-1:0] total_cnt;
   logic [CNT_BITS-1:0] err_cnt;

   tradeoff_w_sequencer #(
      .W_BITS(W_BITS), .N_BITS(N_BITS), .TO_BITS(TO_BITS), .TIMEOUT(TIMEOUT),
      .EXP_N(EXP_N), .CNT_BITS(CNT_BITS)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w),
      .core_w(core_w), .core_start(core_start), .core_found(core_found), .core_n(core_n),
      .res_valid(res_valid), .res_ready(res_ready), .res_w(res_w), .res_n(res_n),
      .res_pass(res_pass), .res_timeout(res_timeout), .busy(busy),
      .total_cnt(total_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Core responder: found rises cfg_delay cycles after start (0 = never);
   // a stale found stays high through START and drops one cycle later.
   int              cfg_delay = 0;
   logic [N_BITS-1:0] cfg_n = '0;
   int              cd = 0;
   bit              armed = 0;
   bit              clr_pend = 0;
   int              starts = 0;

   always @(negedge clk) begin
      if (clr_pend) begin
         core_found = 1'b0;
         clr_pend   = 0;
      end
      if (core_start) begin
         starts++;
         clr_pend = 1;
         cd       = cfg_delay;
         armed    = (cfg_delay > 0);
      end else if (armed) begin
         cd--;
         if (cd == 0) begin
            core_found = 1'b1;
            core_n     = cfg_n;
            armed      = 0;
         end
      end
   end

   int exp_total = 0;
   int exp_err   = 0;

   task automatic reset_pulse(input string tag);
      rst = 1'b1;
      in_valid = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      armed = 0;
      exp_total = 0;
      exp_err = 0;
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_quiet"}, {core_start, res_valid, busy, res_pass, res_timeout}, 0);
      check({tag, "_data"}, {core_w, res_w, res_n}, 0);
      check({tag, "_cnt"}, {total_cnt, err_cnt}, 0);
   endtask

   // One W through the sequencer; keep leaves in_valid high for a burst.
   task automatic run_one(input logic [W_BITS-1:0] w, input int delay,
                          input logic [N_BITS-1:0] n, input int stall, input bit keep);
      int   s, guard, eff;
      bit   to, pass, ok, hold_ok;
      logic [N_BITS-1:0] en;
      logic [30:0] snap;
      guard = 0;
      while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
      cfg_delay = delay;
      cfg_n     = n;
      in_w      = w;
      in_valid  = 1'b1;
      @(negedge clk);
      s = cyc;
      check("start_pulse", core_start, 1);
      check("core_w_latch", core_w, w);
      if (!keep) in_valid = 1'b0;
      to  = (delay == 0) || (delay > TIMEOUT);
      eff = to ? TIMEOUT : delay;
      en  = to ? '0 : n;
      pass = !to && (n == N_BITS'(EXP_N));
      @(negedge clk);
      check("start_one_cycle", core_start, 0);
      ok = 1; guard = 0;
      while (!res_valid && guard < TIMEOUT + 20) begin
         if (core_w !== w || in_ready !== 1'b0) ok = 0;
         @(negedge clk);
         guard++;
      end
      check("res_latency", cyc - s, eff + 1);
      check("core_w_stable", {ok, core_w}, {1'b1, w});
      check("res_fields", {res_w, res_n, res_pass, res_timeout}, {w, en, pass, to});
      snap = {res_w, res_n, res_pass, res_timeout};
      hold_ok = 1;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if ({res_w, res_n, res_pass, res_timeout} !== snap || res_valid !== 1'b1 ||
             in_ready !== 1'b0) hold_ok = 0;
      end
      if (stall > 0) check("stall_hold", hold_ok, 1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      if (exp_total < CNT_MAX) exp_total++;
      if (!pass && exp_err < CNT_MAX) exp_err++;
      check("after_hs_state", {res_valid, in_ready, busy}, 3'b010);
      check("total_cnt", total_cnt, exp_total);
      check("err_cnt", err_cnt, exp_err);
   endtask

   initial begin
      int st0, guard;
      repeat (2) @(negedge clk);
      reset_pulse("reset0");

      run_one(20'h12345, 12, 9'd255, 0, 0);
      run_one(20'd1000, 12, 9'd254, 0, 0);
      run_one(20'hABCDE, 0, 9'd255, 0, 0);
      run_one(20'h00077, TIMEOUT, 9'd255, 0, 0);
      run_one(20'h0BEEF, 7, 9'd255, 20, 0);

      st0 = starts;
      run_one(20'h00001, 4, 9'd255, 0, 1);
      run_one(20'h00002, 5, 9'd3,   0, 1);
      run_one(20'h00003, 6, 9'd255, 0, 0);
      check("burst_starts", starts - st0, 3);

      for (int k = 0; k < 12; k++) begin
         logic [W_BITS-1:0] rw;
         logic [N_BITS-1:0] rn;
         int rd;
         rw = W_BITS'($urandom);
         rd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, TIMEOUT + 5));
         rn = ($urandom_range(0, 1) == 1) ? N_BITS'(EXP_N) : N_BITS'($urandom_range(0, 511));
         run_one(rw, rd, rn, int'($urandom_range(0, 4)), 0);
      end

      cfg_delay = 0;
      in_w = 20'h55555;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_wait_busy", busy, 1);
      reset_pulse("rst_wait");

      cfg_delay = 3;
      cfg_n = 9'd255;
      in_w = 20'h66666;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      guard = 0;
      while (!res_valid && guard < 20) begin @(negedge clk); guard++; end
      check("mid_result_valid", res_valid, 1);
      reset_pulse("rst_result");
      run_one(20'h77777, 10, 9'd100, 0, 0);

      for (int k = 0; k < CNT_MAX + 2; k++) run_one(W_BITS'(k), 2, 9'd255, 0, 0);
      check("sat_total", total_cnt, CNT_MAX);
      run_one(20'h0DEAD, 2, 9'd1, 0, 0);
      check("sat_hold_err", {total_cnt, err_cnt}, {4'(CNT_MAX), 4'(exp_err)});

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/tradeoff_w_sequencer.md
Name: tradeoff_w_sequencer

Overview:
- Upstream feeder and result collector for the Tradeoff_8bits search core.
- Accepts W values over a valid/ready stream and issues one search per W.
- Holds `core_w` stable while the core searches, waits for `found`, then captures N.
- Presents {W, N, pass/timeout} downstream and keeps running pass/error counters, replacing the bench-side wait-for-found loop in the system.

Parameters:
- W_BITS, 20, width of the W operand.
- N_BITS, 9, width of the N result.
- TO_BITS, 10, width of the watchdog counter.
- TIMEOUT, 1000, max WAIT cycles before abort; must be < 2**TO_BITS.
- EXP_N, 255, expected N value for a pass.
- CNT_BITS, 16, width of the total/error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream W available.
- in_ready  out  1  sequencer can accept W.
- in_w  in  W_BITS  W operand.
- core_w  out  W_BITS  W driven to the search core; stable from START until leaving WAIT.
- core_start  out  1  one-cycle pulse that launches a search.
- core_found  in  1  core done flag (level).
- core_n  in  N_BITS  core result, valid while core_found=1.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_w  out  W_BITS  W of this result.
- res_n  out  N_BITS  captured N; 0 on timeout.
- res_pass  out  1  !timeout && res_n==EXP_N.
- res_timeout  out  1  watchdog expired.
- busy  out  1  state != IDLE.
- total_cnt  out  CNT_BITS  results delivered.
- err_cnt  out  CNT_BITS  results delivered with res_pass=0.

Behaviour:
- Reset (sync, rst=1 at rising edge):
  - state=IDLE.
  - All outputs 0 except in_ready=1.
  - core_w=0, counters=0, watchdog=0.
  - rst overrides every transition, including mid-WAIT and mid-RESULT. A pending result is dropped and not counted.
- FSM states: IDLE, START, WAIT, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, latch in_w into core_w and res_w, then go to START.
  - in_ready is 0 in all other states; there is no skid buffer.
- START:
  - core_start=1 for exactly this one cycle.
  - watchdog cleared. core_found ignored (may be stale from the previous search).
  - Next state is WAIT.
- WAIT, watchdog increments each cycle:
  - If core_found=1 at an edge, capture core_n into res_n, clear res_timeout, go to RESULT.
  - Else if watchdog==TIMEOUT-1, set res_n=0 and res_timeout=1, go to RESULT.
  - found and timeout on the same edge: found wins.
- RESULT:
  - res_valid=1. res_w, res_n, res_pass and res_timeout are held until the handshake.
  - On res_valid && res_ready at an edge: total_cnt+=1; err_cnt+=1 if !res_pass; res_valid drops; go to IDLE.
- Latency:
  - in handshake at edge k → core_start high in cycle k+1.
  - core_found first sampled high at edge j → res_valid high from cycle j+1.
  - Best-case throughput is one W per 4 cycles + core search time + downstream stall.
- Counters:
  - Saturate at all-ones; no wrap.
  - err_cnt ≤ total_cnt always.
- res_pass is registered and computed at the capture edge.
- core_w changes only on the IDLE accept edge.

Decomposition:
- Shared package tradeoff_pkg:
  - state enum {IDLE, START, WAIT, RESULT}.
  - Default W_BITS/N_BITS.
  - EXP_N.
  - Default TIMEOUT.
- One natural sub-module, sat_counter, used for total_cnt and err_cnt. It has parameter width and ports clk, rst, inc, q.
- FSM and datapath stay in the top.

Test Plan:
- Single W with a model core whose found rises 12 cycles after core_start with N=255. Required:
  - res_valid exactly 1 cycle after found.
  - res_pass=1, total_cnt=1, err_cnt=0.
  - core_w stable throughout.
- Core returns N=254 for W=1000. Required: res_pass=0, res_n=254, err_cnt=1.
- Core never asserts found. Required:
  - res_timeout=1 and res_n=0 after TIMEOUT cycles in WAIT.
  - err_cnt increments; next W is accepted normally.
- res_ready held low 20 cycles in RESULT, then a 3-W burst with in_valid constantly high. Required:
  - Result fields hold during the stall.
  - in_ready=0 until IDLE.
  - 3 core_start pulses; total_cnt=3.
- rst asserted for 1 cycle mid-WAIT and mid-RESULT. Required:
  - Next cycle IDLE, all outputs at reset values, counters 0.
  - A stale core_found during START is ignored.
- Force total_cnt near max with 2**CNT_BITS+2 passing results, or a small-CNT_BITS build. Required: total_cnt saturates at all-ones and does not wrap.
